// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 16-bit, 4-bit-opcode CPU: opcodes, shift
// sub-functions, ALU ops, control-FSM states and datapath mux encodings.
package cpu_isa_pkg;

  localparam logic [3:0] OP_SHIFT    = 4'b0000;
  localparam logic [3:0] OP_LWD      = 4'b0001;
  localparam logic [3:0] OP_STRWD    = 4'b0010;
  localparam logic [3:0] OP_JMP      = 4'b0011;
  localparam logic [3:0] OP_BRNCHEQ  = 4'b0100;
  localparam logic [3:0] OP_BRNCHNEQ = 4'b0101;
  localparam logic [3:0] OP_ORZEIMD  = 4'b0110;
  localparam logic [3:0] OP_NANDZEIMD= 4'b0111;
  localparam logic [3:0] OP_ADD      = 4'b1000;
  localparam logic [3:0] OP_ADDSEIMD = 4'b1001;
  localparam logic [3:0] OP_ADDZEIMD = 4'b1010;
  localparam logic [3:0] OP_NAND     = 4'b1011;
  localparam logic [3:0] OP_SUB      = 4'b1100;
  localparam logic [3:0] OP_SUBSEIMD = 4'b1101;
  localparam logic [3:0] OP_SUBZEIMD = 4'b1110;
  localparam logic [3:0] OP_OR       = 4'b1111;

  localparam logic [1:0] FUNC_SHL = 2'b01;
  localparam logic [1:0] FUNC_SHR = 2'b10;
  localparam logic [1:0] FUNC_SAR = 2'b11;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SHL  = 3'b010;
  localparam logic [2:0] ALU_SHR  = 3'b011;
  localparam logic [2:0] ALU_SAR  = 3'b100;
  localparam logic [2:0] ALU_NAND = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;

  localparam logic [1:0] ASB_REGB = 2'b00;
  localparam logic [1:0] ASB_ONE  = 2'b01;
  localparam logic [1:0] ASB_IMM  = 2'b10;
  localparam logic [1:0] ASB_OFS  = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EX_ALU   = 4'd2,
    S_EX_BR    = 4'd3,
    S_EX_JMP   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9
  } state_t;

endpackage

// File: rtl/ctrl_ex_decode.sv
// Execute-stage decode for ALU-class instructions: selects ALU op, B operand
// and immediate extension; flags encodings that have no ALU meaning.
module ctrl_ex_decode
  import cpu_isa_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [1:0] func,
  output logic [2:0] alu_op,
  output logic [1:0] alusrc_b,
  output logic       imm_sext,
  output logic       legal
);

  always_comb begin
    alu_op   = ALU_ADD;
    alusrc_b = ASB_REGB;
    imm_sext = 1'b0;
    legal    = 1'b1;
    case (opcode)
      OP_ADD:       alu_op = ALU_ADD;
      OP_SUB:       alu_op = ALU_SUB;
      OP_NAND:      alu_op = ALU_NAND;
      OP_OR:        alu_op = ALU_OR;
      OP_ADDSEIMD: begin
        alusrc_b = ASB_IMM;
        imm_sext = 1'b1;
      end
      OP_SUBSEIMD: begin
        alu_op   = ALU_SUB;
        alusrc_b = ASB_IMM;
        imm_sext = 1'b1;
      end
      OP_ADDZEIMD:  alusrc_b = ASB_IMM;
      OP_SUBZEIMD: begin
        alu_op   = ALU_SUB;
        alusrc_b = ASB_IMM;
      end
      OP_NANDZEIMD: begin
        alu_op   = ALU_NAND;
        alusrc_b = ASB_IMM;
      end
      OP_ORZEIMD: begin
        alu_op   = ALU_OR;
        alusrc_b = ASB_IMM;
      end
      OP_SHIFT: begin
        case (func)
          FUNC_SHL: alu_op = ALU_SHL;
          FUNC_SHR: alu_op = ALU_SHR;
          FUNC_SAR: alu_op = ALU_SAR;
          default:  legal  = 1'b0;
        endcase
      end
      // branches, jump and memory ops never reach the ALU execute state
      default:      legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM: steps each instruction through fetch, decode,
// execute, memory and writeback, with req/ready handshaked memory accesses.
//
// state    | meaning
// FETCH    | read instruction at PC; on ready load IR, PC <= PC+1
// DECODE   | compute branch target into ALUOut, dispatch on opcode
// EX_ALU   | ALU / shift / immediate operation
// EX_BR    | compare regA-regB, conditionally load PC from ALUOut
// EX_JMP   | load PC from jump target
// MEM_ADDR | compute effective address regA + offset
// MEM_RD   | load request at ALUOut, held until ready
// MEM_WR   | store request at ALUOut, held until ready
// WB_ALU   | write ALUOut to register file
// WB_MEM   | write MDR to register file
module multicycle_ctrl_fsm
  import cpu_isa_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         opcode,
  input  logic [1:0]         func,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               alusrc_a,
  output logic [1:0]         alusrc_b,
  output logic               imm_sext,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_t     state_q, state_d;
  logic [2:0] dec_alu_op;
  logic [1:0] dec_alusrc_b;
  logic       dec_imm_sext, dec_legal;

  logic       mem_req_c, mem_we_c, iord_c, ir_write_c, pc_write_c;
  logic [1:0] pc_src_c, alusrc_b_c;
  logic       alusrc_a_c, imm_sext_c, reg_write_c, mem_to_reg_c, illegal_c;
  logic [2:0] alu_op_c;

  ctrl_ex_decode u_ex_decode (
    .opcode   (opcode),
    .func     (func),
    .alu_op   (dec_alu_op),
    .alusrc_b (dec_alusrc_b),
    .imm_sext (dec_imm_sext),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    iord_c       = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = PCS_ALU;
    alusrc_a_c   = 1'b0;
    alusrc_b_c   = ASB_REGB;
    imm_sext_c   = 1'b0;
    alu_op_c     = ALU_ADD;
    reg_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;
    illegal_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          alusrc_b_c = ASB_ONE;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrc_b_c = ASB_OFS;
        imm_sext_c = 1'b1;
        case (opcode)
          OP_BRNCHEQ, OP_BRNCHNEQ: state_d = S_EX_BR;
          OP_JMP:                  state_d = S_EX_JMP;
          OP_LWD, OP_STRWD:        state_d = S_MEM_ADDR;
          default:                 state_d = S_EX_ALU;
        endcase
      end
      S_EX_ALU: begin
        alusrc_a_c = 1'b1;
        alusrc_b_c = dec_alusrc_b;
        imm_sext_c = dec_imm_sext;
        alu_op_c   = dec_alu_op;
        if (dec_legal) begin
          state_d = S_WB_ALU;
        end else begin
          illegal_c = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EX_BR: begin
        alusrc_a_c = 1'b1;
        alu_op_c   = ALU_SUB;
        pc_src_c   = PCS_ALUOUT;
        pc_write_c = ((opcode == OP_BRNCHEQ) &  alu_zero) |
                     ((opcode == OP_BRNCHNEQ) & ~alu_zero);
        state_d    = S_FETCH;
      end
      S_EX_JMP: begin
        pc_write_c = 1'b1;
        pc_src_c   = PCS_JUMP;
        state_d    = S_FETCH;
      end
      S_MEM_ADDR: begin
        alusrc_a_c = 1'b1;
        alusrc_b_c = ASB_OFS;
        imm_sext_c = 1'b1;
        state_d    = (opcode == OP_STRWD) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        iord_c    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_WB_ALU: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        state_d      = S_FETCH;
      end
      default: begin
        illegal_c = 1'b1;
        state_d   = S_FETCH;
      end
    endcase
  end

  // Outputs are forced low for as long as reset is held, not just after the edge.
  assign mem_req    = rst_n & mem_req_c;
  assign mem_we     = rst_n & mem_we_c;
  assign iord       = rst_n & iord_c;
  assign ir_write   = rst_n & ir_write_c;
  assign pc_write   = rst_n & pc_write_c;
  assign pc_src     = {2{rst_n}} & pc_src_c;
  assign alusrc_a   = rst_n & alusrc_a_c;
  assign alusrc_b   = {2{rst_n}} & alusrc_b_c;
  assign imm_sext   = rst_n & imm_sext_c;
  assign alu_op     = {ALUOP_W{rst_n}} & ALUOP_W'(alu_op_c);
  assign reg_write  = rst_n & reg_write_c;
  assign mem_to_reg = rst_n & mem_to_reg_c;
  assign illegal_op = rst_n & illegal_c;
  assign state      = {STATE_W{rst_n}} & STATE_W'(state_q);

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Multi-cycle control unit for the 16-bit, 4-bit-opcode CPU. It steps each instruction through fetch, decode, execute, memory and writeback states. It drives the register-file, ALU, PC and memory strobes that the datapath and the register-select logic act on. Memory accesses use a req/ready handshake, so one instruction takes a variable number of cycles.

Parameters:
ALUOP_W, 3, width of alu_op output
STATE_W, 4, width of debug state output

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  4  IR[15:12], valid from DECODE onward
func  in  2  IR[1:0], shift sub-function
alu_zero  in  1  ALU result==0, combinational from datapath
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  1=write, valid while mem_req
iord  out  1  memory address source: 0=PC, 1=ALUOut
ir_write  out  1  load IR from memory data
pc_write  out  1  load PC
pc_src  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target
alusrc_a  out  1  0=PC, 1=regA
alusrc_b  out  2  00=regB, 01=const 1, 10=extended imm, 11=extended offset
imm_sext  out  1  1=sign-extend immediate, 0=zero-extend
alu_op  out  ALUOP_W  000 ADD, 001 SUB, 010 SHL, 011 SHR, 100 SAR, 101 NAND, 110 OR
reg_write  out  1  register-file write enable
mem_to_reg  out  1  writeback data source: 0=ALUOut, 1=MDR
illegal_op  out  1  one-cycle pulse on an undefined encoding
state  out  STATE_W  current state, for debug

Behaviour:
- Reset (rst_n low, asynchronous): state=FETCH. Every output is 0 while reset is asserted. Any in-flight memory request is dropped.
- States: FETCH=0, DECODE=1, EX_ALU=2, EX_BR=3, EX_JMP=4, MEM_ADDR=5, MEM_RD=6, MEM_WR=7, WB_ALU=8, WB_MEM=9.
- Outputs are Moore, decoded from the state register. In the branch and memory states they are also qualified by opcode, alu_zero and mem_ready. No output is ever X.
- FETCH: mem_req=1, iord=0.
  - While mem_ready=0: stay in FETCH, no other strobes.
  - On mem_ready=1, in the same cycle: ir_write=1, pc_write=1, pc_src=00, alusrc_a=0, alusrc_b=01, ADD. Next state is DECODE.
- DECODE: alusrc_a=0, alusrc_b=11, imm_sext=1, ADD (branch target is latched into ALUOut). Next state by opcode:
  - 1000, 1001, 1010, 1100, 1101, 1110, 0000, 1011, 0111, 1111, 0110 -> EX_ALU
  - 0100, 0101 -> EX_BR
  - 0011 -> EX_JMP
  - 0001, 0010 -> MEM_ADDR
- EX_ALU: alusrc_a=1. Per opcode:
  - reg forms (1000 add, 1100 sub, 1011 nand, 1111 or): alusrc_b=00.
  - 1001, 1101: alusrc_b=10, imm_sext=1.
  - 1010, 1110, 0111, 0110: alusrc_b=10, imm_sext=0.
  - 0000 shift: alusrc_b=00, func 01->SHL, 10->SHR, 11->SAR.
  - shift with func=00: illegal_op=1, next state FETCH, no writeback.
  - Otherwise next state is WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0. Next state FETCH.
- EX_BR: alusrc_a=1, alusrc_b=00, SUB.
  - pc_write = (opcode==0100 & alu_zero) | (opcode==0101 & ~alu_zero), with pc_src=01.
  - Next state FETCH.
- EX_JMP: pc_write=1, pc_src=10. Next state FETCH.
- MEM_ADDR: alusrc_a=1, alusrc_b=11, imm_sext=1, ADD. Next state MEM_RD for 0001, MEM_WR for 0010.
- MEM_RD: mem_req=1, mem_we=0, iord=1. Hold until mem_ready=1, then go to WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, iord=1. Hold until mem_ready=1, then go to FETCH.
- WB_MEM: reg_write=1, mem_to_reg=1. Next state FETCH.
- Cycle counts with zero-wait memory:
  - ALU ops: 4 cycles
  - branch, jump: 3 cycles
  - lwd: 5 cycles
  - strwd: 4 cycles
- Each wait cycle extends FETCH, MEM_RD or MEM_WR by one cycle.
- mem_req, mem_we and iord stay stable for the whole request. mem_ready arriving outside a request state is ignored.
- An illegal state encoding (10-15) recovers to FETCH on the next clock and pulses illegal_op.
- rst_n deasserting is synchronised externally. The first request after reset is FETCH with mem_req=1.

Decomposition:
- Shared package cpu_isa_pkg:
  - the 16 opcode constants and the func constants shl/shr/sar
  - ALU op codes, state encodings, alusrc_b and pc_src encodings
- The same package is also used by the register-select logic.
- Sub-module ctrl_ex_decode: combinational opcode/func -> {alu_op, alusrc_b, imm_sext, legal}. The FSM instantiates it once.

Test Plan:
- Reset mid-MEM_RD (rst_n low while mem_req=1): all outputs 0 immediately. After release, state=0 with mem_req=1, iord=0.
- addseimd 1001, zero-wait memory: 4 cycles, states 0,1,2,8. EX_ALU shows alusrc_b=10, imm_sext=1, alu_op=000. reg_write=1 only in cycle 4.
- shift 0000 with func=11: alu_op=100 in EX_ALU. With func=00: illegal_op pulses once, reg_write stays 0, next state=0.
- brncheq 0100: with alu_zero=1, pc_write=1 and pc_src=01 in EX_BR. With alu_zero=0, pc_write=0. brnchneq 0101 gives the inverse.
- lwd 0001 with 2 mem_ready wait cycles in both FETCH and MEM_RD: 9 cycles total. mem_req held high, iord=1 during MEM_RD. WB_MEM has reg_write=1, mem_to_reg=1.
- strwd 0010, then jmp 0011 back-to-back: MEM_WR has mem_we=1 and no reg_write. The jump takes 3 cycles with pc_src=10.
